lbist_prpg: RTL
===============

// Module: lbist_prpg
// PURPOSE
//  Parametrised pseudo-random pattern generator and controller for logic BIST.
//  Runtime-programmable Fibonacci LFSR drives CHANNELS scan chains through an XOR phase shifter.
//  Sequences shift/capture cycles for a programmed pattern count; start/busy/done handshake.
//  Sits between the BIST controller (config, start) and the scan chains of the core under test.
// PARAMETERS
//  WIDTH     32   LFSR length in bits (>=4)
//  CHANNELS  4    scan chain outputs; CHANNELS <= WIDTH/2
//  SHIFT_LEN 64   shift cycles per pattern (>=1)
//  CNT_W     16   width of pattern counter / num_patterns
// PORTS
//  clk           in   1         clock, rising edge
//  reset         in   1         asynchronous, active-high
//  start         in   1         begin run; sampled only in IDLE
//  abort         in   1         cancel run from any state
//  poly          in   WIDTH     tap mask: bit i=1 -> lfsr[i] feeds XOR; sampled in LOAD
//  seed          in   WIDTH     initial LFSR state; sampled in LOAD
//  num_patterns  in   CNT_W     patterns per run; sampled in LOAD
//  scan_en       out  1         1 during SHIFT
//  chan_out      out  CHANNELS  scan-in data per chain
//  capture       out  1         one-cycle capture pulse
//  busy          out  1         1 in LOAD/SHIFT/CAPTURE
//  done          out  1         one-cycle pulse at run completion
//  seed_err      out  1         sticky: seed==0 or poly[WIDTH-1]==0 at LOAD; cleared at next start
//  lfsr_state    out  WIDTH     current LFSR register
//  pat_cnt       out  CNT_W     completed patterns in current run
// BEHAVIOUR
//  Reset: state IDLE; lfsr=1; pat_cnt=0; shift_cnt=0; all 1-bit outputs 0; chan_out=phase(lfsr).
//  LFSR step: fb = ^(lfsr & poly_q); lfsr_next = {lfsr[WIDTH-2:0], fb}. Advances only in SHIFT.
//  Phase shifter (comb): chan_out[c] = lfsr[c] ^ lfsr[c+WIDTH/2], c=0..CHANNELS-1; valid in every state.
//  FSM:
//   IDLE:    start & !abort -> LOAD; seed_err cleared.
//   LOAD:    1 cycle. poly_q<=poly; npat_q<=num_patterns; lfsr<=(seed==0)?1:seed;
//            pat_cnt<=0; shift_cnt<=0; set seed_err on bad seed/poly.
//            npat==0 -> DONE, else -> SHIFT.
//   SHIFT:   scan_en=1; lfsr steps; shift_cnt++. At shift_cnt==SHIFT_LEN-1 -> CAPTURE, shift_cnt<=0.
//   CAPTURE: 1 cycle; capture=1, scan_en=0, lfsr holds; pat_cnt++.
//            pat_cnt+1==npat_q -> DONE, else -> SHIFT.
//   DONE:    done=1 for 1 cycle -> IDLE. pat_cnt and lfsr hold until next LOAD.
//  Outputs registered from state: scan_en, capture, busy, done are 1 only in SHIFT, CAPTURE,
//   LOAD/SHIFT/CAPTURE, DONE respectively.
//  Latency: start high at cycle t -> LOAD at t+1 -> first scan_en at t+2.
//   Run length = 2 + npat*(SHIFT_LEN+1) cycles to done.
//  start while busy: ignored. abort & start together: abort wins.
//  abort: any state -> IDLE next edge; no done; lfsr/pat_cnt hold.
//  Counters are CNT_W / clog2(SHIFT_LEN+1) wide; pat_cnt never wraps (max npat = 2^CNT_W-1).
//  Reset mid-run: immediate return to reset values; no done pulse.
//  Zero-lockup: lfsr never loaded with 0. A non-primitive poly is legal; only seed_err checks apply.
// STRUCTURE
//  Package lbist_pkg: FSM state enum (IDLE, LOAD, SHIFT, CAPTURE, DONE);
//   default polynomial constants per width (e.g. POLY_4=4'b1100, POLY_16, POLY_32).
//  Sub-module lbist_phase_shifter (comb, WIDTH/CHANNELS params), reused by the MISR side later.
//  Top holds FSM, counters, LFSR register.
// TESTING
//  1 WIDTH=4, poly=4'b1100, seed=0001, npat=1, SHIFT_LEN=15 -> lfsr 0001,0010,0100,1001,...,1000;
//    back to 0001 after 15 steps; period 15.
//  2 npat=3, SHIFT_LEN=4 -> scan_en high 4 cycles, capture 1 cycle, x3;
//    done exactly 2+3*5=17 cycles after start; pat_cnt=3.
//  3 seed=0, poly valid -> lfsr loads 1, seed_err=1; next start with good seed clears seed_err.
//  4 npat=0 -> LOAD then DONE; no scan_en/capture; done 2 cycles after start.
//  5 abort during SHIFT of pattern 2 -> IDLE next cycle; no done; start re-runs from seed.
//    start pulses while busy have no effect.
//  6 assert reset mid-SHIFT -> outputs immediately at reset values; lfsr=1; busy=0.

Source files
------------

// File: rtl/lbist_pkg.sv
// rtl/lbist_pkg.sv - shared types and constants for the logic BIST pattern generator
//
// Purpose: FSM state encoding for the PRPG controller and default maximal-length
// tap masks (bit i set -> lfsr[i] feeds the XOR), usable as poly values.
package lbist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_SHIFT   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } lbist_state_e;

    // Taps x^4+x^3+1, x^8+x^6+x^5+x^4+1, x^16+x^14+x^13+x^11+1, x^32+x^22+x^2+x+1
    localparam logic [3:0]  POLY_4  = 4'b1100;
    localparam logic [7:0]  POLY_8  = 8'hB8;
    localparam logic [15:0] POLY_16 = 16'hB400;
    localparam logic [31:0] POLY_32 = 32'h8020_0003;

endpackage

// File: rtl/lbist_phase_shifter.sv
// rtl/lbist_phase_shifter.sv - XOR phase shifter spreading LFSR state over scan channels
//
// Purpose: decorrelates adjacent scan chains by pairing each low LFSR bit with the
// bit half a register away. Purely combinational.
// Ports:
//   lfsr_i  [WIDTH-1:0]     LFSR register contents
//   chan_o  [CHANNELS-1:0]  chan_o[c] = lfsr_i[c] ^ lfsr_i[c+WIDTH/2]
module lbist_phase_shifter #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4
) (
    input  logic [WIDTH-1:0]    lfsr_i,
    output logic [CHANNELS-1:0] chan_o
);

    localparam int HALF = WIDTH / 2;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        assign chan_o[c] = lfsr_i[c] ^ lfsr_i[c+HALF];
    end

endmodule

// File: rtl/lbist_prpg.sv
// rtl/lbist_prpg.sv - logic BIST pseudo-random pattern generator and shift/capture sequencer
//
// Purpose: programmable Fibonacci LFSR feeding CHANNELS scan chains via a phase
// shifter; sequences SHIFT_LEN shift cycles plus one capture per pattern for a
// programmed number of patterns, with start/busy/done handshake and abort.
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-high reset
//   start, abort          run request (IDLE only) / cancel from any state
//   poly, seed            tap mask and initial state, sampled in LOAD
//   num_patterns          patterns per run, sampled in LOAD
//   scan_en, capture      shift enable / one-cycle capture pulse
//   busy, done            run in progress / one-cycle completion pulse
//   seed_err              sticky bad seed/poly flag, cleared on next accepted start
//   chan_out              scan-in data per chain
//   lfsr_state, pat_cnt   LFSR register / completed patterns in current run
module lbist_prpg
    import lbist_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int CHANNELS  = 4,
    parameter int SHIFT_LEN = 64,
    parameter int CNT_W     = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [WIDTH-1:0]    poly,
    input  logic [WIDTH-1:0]    seed,
    input  logic [CNT_W-1:0]    num_patterns,
    output logic                scan_en,
    output logic [CHANNELS-1:0] chan_out,
    output logic                capture,
    output logic                busy,
    output logic                done,
    output logic                seed_err,
    output logic [WIDTH-1:0]    lfsr_state,
    output logic [CNT_W-1:0]    pat_cnt
);

    localparam int              SC_W       = $clog2(SHIFT_LEN + 1);
    localparam logic [SC_W-1:0] SHIFT_LAST = SC_W'(SHIFT_LEN - 1);
    localparam logic [WIDTH-1:0] LFSR_ONE  = WIDTH'(1);

    lbist_state_e      state_q;
    logic [WIDTH-1:0]  lfsr_q;
    logic [WIDTH-1:0]  lfsr_d;
    logic [WIDTH-1:0]  poly_q;
    logic [CNT_W-1:0]  npat_q;
    logic [CNT_W-1:0]  pat_cnt_q;
    logic [SC_W-1:0]   shift_cnt_q;
    logic              scan_en_q;
    logic              capture_q;
    logic              busy_q;
    logic              done_q;
    logic              seed_err_q;

    always_comb begin
        lfsr_d = {lfsr_q[WIDTH-2:0], ^(lfsr_q & poly_q)};
    end

    // Status outputs are registered alongside the state transition so each one
    // is high exactly while the FSM sits in the corresponding state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            lfsr_q      <= LFSR_ONE;
            poly_q      <= '0;
            npat_q      <= '0;
            pat_cnt_q   <= '0;
            shift_cnt_q <= '0;
            scan_en_q   <= 1'b0;
            capture_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            seed_err_q  <= 1'b0;
        end else if (abort) begin
            // Cancel without a done pulse; LFSR and pattern count are left as-is.
            state_q   <= ST_IDLE;
            scan_en_q <= 1'b0;
            capture_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q    <= ST_LOAD;
                        busy_q     <= 1'b1;
                        seed_err_q <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    poly_q      <= poly;
                    npat_q      <= num_patterns;
                    // A zero state would lock the LFSR, so substitute 1.
                    lfsr_q      <= (seed == '0) ? LFSR_ONE : seed;
                    pat_cnt_q   <= '0;
                    shift_cnt_q <= '0;
                    seed_err_q  <= (seed == '0) || !poly[WIDTH-1];
                    if (num_patterns == '0) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q   <= ST_SHIFT;
                        scan_en_q <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    lfsr_q <= lfsr_d;
                    if (shift_cnt_q == SHIFT_LAST) begin
                        state_q     <= ST_CAPTURE;
                        shift_cnt_q <= '0;
                        scan_en_q   <= 1'b0;
                        capture_q   <= 1'b1;
                    end else begin
                        shift_cnt_q <= shift_cnt_q + SC_W'(1);
                    end
                end
                ST_CAPTURE: begin
                    pat_cnt_q <= pat_cnt_q + CNT_W'(1);
                    capture_q <= 1'b0;
                    // pat_cnt_q+1 never exceeds npat_q, so the truncated sum is exact.
                    if ((pat_cnt_q + CNT_W'(1)) == npat_q) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q   <= ST_SHIFT;
                        scan_en_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    scan_en_q <= 1'b0;
                    capture_q <= 1'b0;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

    lbist_phase_shifter #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS)
    ) u_phase_shifter (
        .lfsr_i (lfsr_q),
        .chan_o (chan_out)
    );

    assign scan_en    = scan_en_q;
    assign capture    = capture_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign seed_err   = seed_err_q;
    assign lfsr_state = lfsr_q;
    assign pat_cnt    = pat_cnt_q;

endmodule
